// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction ROM port arbiter.
// Port IDs, default NOP word and the word-index slice of a byte address.
package imem_port_arbiter_pkg;

    typedef logic [1:0] port_t;

    localparam port_t PORT_NONE = 2'd0;
    localparam port_t PORT_F    = 2'd1;
    localparam port_t PORT_D    = 2'd2;

    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

    localparam int WORD_LSB = 2;
    localparam int WORD_MSB = 9;

endpackage

// File: rtl/imem_grant_logic.sv
// Combinational grant decision: lock, then forced debug, then fetch, then debug.
// Holds no state; the parent owns wait_cnt and lock_q.
module imem_grant_logic
    import imem_port_arbiter_pkg::*;
#(
    parameter int WW       = 3,
    parameter int MAX_WAIT = 4
) (
    input  logic          f_req,
    input  logic          d_req,
    input  logic          lock_q,
    input  logic [WW-1:0] wait_cnt,
    output port_t         winner
);

    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    always_comb begin
        winner = PORT_NONE;
        if (lock_q && d_req) begin
            winner = PORT_D;
        end else if ((wait_cnt == WMAX) && d_req) begin
            winner = PORT_D;
        end else if (f_req) begin
            winner = PORT_F;
        end else if (d_req) begin
            winner = PORT_D;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction ROM between fetch and debug readers.
// Define IMEM_ARB_RANGE_CHECK_EN to return NOP_WORD and flag err on out-of-range reads.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int          DEPTH    = 64,
    parameter int          MAX_WAIT = 4,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [30:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_lock,
    input  logic [30:0] d_addr,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic [30:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        err
);

    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

`ifdef IMEM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic [WW-1:0] wait_cnt;
    logic          lock_q;
    port_t         winner;
    logic [30:0]   sel_addr;
    logic [7:0]    widx;
    logic          oor;
    logic          oor_hit;
    logic [31:0]   rd_word;

    imem_grant_logic #(
        .WW       (WW),
        .MAX_WAIT (MAX_WAIT)
    ) u_grant (
        .f_req    (f_req),
        .d_req    (d_req),
        .lock_q   (lock_q),
        .wait_cnt (wait_cnt),
        .winner   (winner)
    );

    assign f_gnt = (winner == PORT_F);
    assign d_gnt = (winner == PORT_D);

    // With no winner the fetch address is kept so the ROM bus stays quiet.
    assign sel_addr = d_gnt ? d_addr : f_addr;
    assign rom_addr = sel_addr;

    assign widx    = sel_addr[WORD_MSB:WORD_LSB];
    assign oor     = ({24'd0, widx} >= DEPTH) || (|sel_addr[30:WORD_MSB+1]);
    assign oor_hit = RANGE_EN && (f_gnt || d_gnt) && oor;
    assign rd_word = oor_hit ? NOP_WORD : rom_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= f_gnt;
            d_rvalid <= d_gnt;
            if (f_gnt) f_rdata <= rd_word;
            if (d_gnt) d_rdata <= rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (d_req && !d_gnt) begin
            if (wait_cnt != WMAX) wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Lock is taken only on a granted locked read and released as soon as
    // the debug side lets go of either lock or request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_q <= 1'b0;
        end else if (d_gnt && d_lock) begin
            lock_q <= 1'b1;
        end else if (!d_lock || !d_req) begin
            lock_q <= 1'b0;
        end
    end

`ifdef IMEM_ARB_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (oor_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small ROM table model.
// Expectations follow the build's IMEM_ARB_RANGE_CHECK_EN setting.
module tb_imem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [30:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_lock;
    logic [30:0] d_addr;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [30:0] rom_addr;
    logic [31:0] rom_data;
    logic        err;

    int total;
    int bad;

    imem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .d_req    (d_req),
        .d_lock   (d_lock),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [7:0] idx);
        case (idx)
            8'd0:    return 32'h0800_0003;
            8'd4:    return 32'h8c96_0000;
            8'd27:   return 32'h2018_0001;
            8'd28:   return 32'h2019_0001;
            default: return {16'ha5a5, 8'h00, idx};
        endcase
    endfunction

    always_comb rom_data = rom_word(rom_addr[9:2]);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_oor;
    logic [31:0] exp_err;

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        f_req = 1'b0;
        f_addr = '0;
        d_req = 1'b0;
        d_lock = 1'b0;
        d_addr = '0;

`ifdef IMEM_ARB_RANGE_CHECK_EN
        exp_oor = 32'h0000_0000;
        exp_err = 32'd1;
`else
        exp_oor = 32'h0800_0003;
        exp_err = 32'd0;
`endif

        tick();
        tick();
        chk("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // First fetch after reset release
        reset = 1'b1;
        f_req = 1'b1;
        f_addr = 31'h0;
        #1;
        chk("f0_gnt", {31'd0, f_gnt}, 32'd1);
        chk("f0_dgnt", {31'd0, d_gnt}, 32'd0);
        tick();
        chk("f0_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("f0_rdata", f_rdata, 32'h0800_0003);
        chk("f0_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        f_req = 1'b0;
        #1;
        chk("idle_fgnt", {31'd0, f_gnt}, 32'd0);
        chk("idle_dgnt", {31'd0, d_gnt}, 32'd0);
        f_addr = 31'h24;
        #1;
        chk("idle_rom_addr", {1'b0, rom_addr}, 32'h24);
        tick();
        chk("idle_f_rvalid", {31'd0, f_rvalid}, 32'd0);

        // Fetch starves debug for MAX_WAIT cycles, then debug is forced
        f_req = 1'b1;
        d_req = 1'b1;
        d_addr = 31'h10;
        for (int i = 0; i < 4; i++) begin
            f_addr = 31'(4 * i);
            #1;
            chk($sformatf("wait%0d_fgnt", i), {31'd0, f_gnt}, 32'd1);
            chk($sformatf("wait%0d_dgnt", i), {31'd0, d_gnt}, 32'd0);
            tick();
            chk($sformatf("wait%0d_rdata", i), f_rdata, rom_word(8'(i)));
            chk($sformatf("wait%0d_rvalid", i), {31'd0, f_rvalid}, 32'd1);
        end
        #1;
        chk("force_dgnt", {31'd0, d_gnt}, 32'd1);
        chk("force_fgnt", {31'd0, f_gnt}, 32'd0);
        chk("force_rom_addr", {1'b0, rom_addr}, 32'h10);
        tick();
        chk("force_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("force_d_rdata", d_rdata, 32'h8c96_0000);
        chk("force_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        d_req = 1'b0;
        #1;
        chk("resume_fgnt", {31'd0, f_gnt}, 32'd1);
        tick();
        chk("resume_f_rvalid", {31'd0, f_rvalid}, 32'd1);

        // Locked debug dump holds off fetch
        f_req = 1'b0;
        d_req = 1'b1;
        d_lock = 1'b1;
        d_addr = 31'h6c;
        #1;
        chk("lock0_dgnt", {31'd0, d_gnt}, 32'd1);
        tick();
        chk("lock0_rdata", d_rdata, 32'h2018_0001);
        f_req = 1'b1;
        d_addr = 31'h70;
        #1;
        chk("lock1_dgnt", {31'd0, d_gnt}, 32'd1);
        chk("lock1_fgnt", {31'd0, f_gnt}, 32'd0);
        tick();
        chk("lock1_rdata", d_rdata, 32'h2019_0001);
        chk("lock1_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        d_lock = 1'b0;
        #1;
        chk("unlock_held_dgnt", {31'd0, d_gnt}, 32'd1);
        tick();
        d_req = 1'b0;
        #1;
        chk("unlock_fgnt", {31'd0, f_gnt}, 32'd1);
        tick();
        chk("unlock_f_rvalid", {31'd0, f_rvalid}, 32'd1);

        // Reset during a granted fetch drops the read
        f_addr = 31'h8;
        #1;
        chk("rstf_fgnt", {31'd0, f_gnt}, 32'd1);
        reset = 1'b0;
        tick();
        chk("rstf_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("rstf_f_rdata", f_rdata, 32'd0);
        chk("rstf_d_rdata", d_rdata, 32'd0);
        chk("rstf_err", {31'd0, err}, 32'd0);
        f_req = 1'b0;
        reset = 1'b1;
        tick();
        chk("rstf_after", {31'd0, f_rvalid}, 32'd0);

        // Out-of-range debug read, then a legal one
        d_req = 1'b1;
        d_addr = 31'h400;
        #1;
        chk("oor_dgnt", {31'd0, d_gnt}, 32'd1);
        tick();
        chk("oor_rdata", d_rdata, exp_oor);
        chk("oor_err", {31'd0, err}, exp_err);
        d_addr = 31'h10;
        tick();
        chk("legal_rdata", d_rdata, 32'h8c96_0000);
        chk("legal_err", {31'd0, err}, exp_err);
        d_req = 1'b0;
        tick();
        chk("end_d_rvalid", {31'd0, d_rvalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
